serial_demux_collector: RTL and testbench

- Receive-side counterpart of the N:1 mux serializer path. The mux emits data[sel] while sel sweeps 0..WIDTH-1 (LSB first); this block demultiplexes each incoming bit into position sel of a WIDTH-bit word.
- It presents the completed word on a valid/ready output and back-pressures the serial side while an unconsumed word is held.
- It sits between a bit-serial link and any parallel consumer.

---
 rtl/serial_mux_pkg.sv | 18 +
 rtl/demux_bit_index.sv | 33 +++
 rtl/serial_demux_collector.sv | 91 +++++++++
 tb/tb_serial_demux_collector.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/serial_mux_pkg.sv
// serial_mux_pkg: definitions shared by the bit-serial mux/demux path.
//   state_t       - collector FSM states
//   sel_width()   - bit-index width for a given word width
//   DEFAULT_WIDTH - default word width
package serial_mux_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 16;

    function automatic int sel_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/demux_bit_index.sv
// demux_bit_index: bit-position counter for the serial collector.
// Ports:
//   clk, rst_n - clock, async active-low reset
//   clear      - synchronous return to 0 (priority over enable)
//   enable     - advance by one (one accepted bit)
//   idx        - current bit position
//   terminal   - idx is the last position of the word
module demux_bit_index #(
    parameter int WIDTH     = 16,
    parameter int SEL_WIDTH = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 enable,
    output logic [SEL_WIDTH-1:0] idx,
    output logic                 terminal
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idx <= '0;
        else if (clear)
            idx <= '0;
        else if (enable)
            // WIDTH is a power of two, so the increment past the last
            // position wraps to 0 exactly on the word-complete edge.
            idx <= idx + 1'b1;
    end

    assign terminal = (idx == SEL_WIDTH'(WIDTH - 1));

endmodule

// File: rtl/serial_demux_collector.sv
// serial_demux_collector: collects LSB-first serial bits into a WIDTH-bit
// word and offers it on a valid/ready port, stalling the serial side while
// the completed word is unconsumed.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   in_bit, in_valid    - serial input; transfer when in_valid && in_ready
//   in_ready            - serial side may transfer this cycle
//   flush               - drop a partially collected word (ignored in HOLD)
//   out_data, out_valid - assembled word / word complete
//   out_ready           - consumer takes the word
//   fill_level          - bits collected so far (WIDTH while holding)
module serial_demux_collector
    import serial_mux_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int SEL_WIDTH = sel_width(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_bit,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SEL_WIDTH:0]   fill_level
);

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     word;
    logic [SEL_WIDTH-1:0] idx;
    logic                 terminal;
    logic                 accept;
    logic                 flush_fill;

    // In HOLD the index already sits at 0, so a bit arriving together with
    // the handshake lands in position 0 of the next word without a bubble.
    assign in_ready   = (state == FILL) ? !flush : out_ready;
    assign accept     = in_valid && in_ready;
    assign flush_fill = (state == FILL) && flush;

    demux_bit_index #(
        .WIDTH     (WIDTH),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_idx (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (flush_fill),
        .enable   (accept),
        .idx      (idx),
        .terminal (terminal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= FILL;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FILL: if (accept && terminal) state_nxt = HOLD;
            HOLD: if (out_ready)          state_nxt = FILL;
        endcase
    end

    // Position 0 rewrites the whole word so stale upper bits never leak
    // into the partial view; a bare handshake also clears the register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            word <= '0;
        else if (flush_fill)
            word <= '0;
        else if (accept) begin
            if (idx == '0)
                word <= {{(WIDTH-1){1'b0}}, in_bit};
            else
                word[idx] <= in_bit;
        end
        else if (state == HOLD && out_ready)
            word <= '0;
    end

    assign out_data   = word;
    assign out_valid  = (state == HOLD);
    assign fill_level = (state == HOLD) ? (SEL_WIDTH+1)'(WIDTH) : {1'b0, idx};

endmodule

// File: tb/tb_serial_demux_collector.sv
module tb_serial_demux_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_bit;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  fill_level;

    int n_chk  = 0;
    int n_pass = 0;

    serial_demux_collector #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_bit     (in_bit),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fill_level (fill_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, act, exp);
    endtask

    // Drives the 16 bits LSB first, one per cycle; returns right after
    // driving the last bit (it is taken on the following rising edge).
    task automatic send_word(input logic [15:0] w);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_bit   = w[i];
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ov"}, 32'(out_valid), 32'd0);
        chk({tag, "_od"}, 32'(out_data), 32'h0);
        chk({tag, "_fl"}, 32'(fill_level), 32'd0);
        chk({tag, "_ir"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        rst_n = 1'b1; in_bit = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;

        // asynchronous reset, no clock edge involved
        #3 rst_n = 1'b0;
        #1 chk_reset_vals("rst");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // single word with ready consumer
        out_ready = 1'b1;
        w = 16'hA5C3;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 8) begin
                chk("sw_fl8", 32'(fill_level), 32'd8);
                chk("sw_part", 32'(out_data), 32'h00C3);
                chk("sw_ov8", 32'(out_valid), 32'd0);
            end
            in_valid = 1'b1;
            in_bit   = w[i];
        end
        @(negedge clk);
        chk("sw_ov", 32'(out_valid), 32'd1);
        chk("sw_od", 32'(out_data), 32'hA5C3);
        chk("sw_fl", 32'(fill_level), 32'd16);
        in_valid = 1'b0;
        @(negedge clk);
        chk("sw_ov_off", 32'(out_valid), 32'd0);
        chk("sw_fl_off", 32'(fill_level), 32'd0);

        // backpressure
        out_ready = 1'b0;
        send_word(16'hFFFF);
        @(negedge clk);
        in_valid = 1'b1; in_bit = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_ir", 32'(in_ready), 32'd0);
            chk("bp_ov", 32'(out_valid), 32'd1);
            chk("bp_od", 32'(out_data), 32'hFFFF);
            chk("bp_fl", 32'(fill_level), 32'd16);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 chk("bp_ir_pass", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_fl1", 32'(fill_level), 32'd1);
        chk("bp_ov0", 32'(out_valid), 32'd0);
        chk("bp_od0", 32'(out_data), 32'h0000);
        // finish that word so the sweep starts at a word boundary
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_bit = 1'b0;
        end
        @(negedge clk);
        chk("bp_w2_ov", 32'(out_valid), 32'd1);
        chk("bp_w2_od", 32'(out_data), 32'h0000);
        in_valid = 1'b0;

        // one-hot sweep, back to back
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            if (k > 0 && k % 16 == 0) begin
                chk("oh_ov", 32'(out_valid), 32'd1);
                chk("oh_od", 32'(out_data), 32'(16'd1 << (k/16 - 1)));
                for (int j = 0; j < 16; j++)
                    chk("oh_bit", 32'(out_data[j]), 32'((k/16 - 1) == j));
            end else if (k > 0) begin
                chk("oh_ov_idle", 32'(out_valid), 32'd0);
            end
            in_valid = 1'b1;
            in_bit   = ((k % 16) == (k / 16));
        end
        @(negedge clk);
        chk("oh_ov_last", 32'(out_valid), 32'd1);
        chk("oh_od_last", 32'(out_data), 32'h8000);
        in_valid = 1'b0;

        // flush of a partial word
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_bit = 1'b1;
        end
        @(negedge clk);
        chk("fl_fl7", 32'(fill_level), 32'd7);
        chk("fl_part", 32'(out_data), 32'h007F);
        flush = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        #1 chk("fl_ir", 32'(in_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_fl0", 32'(fill_level), 32'd0);
        chk("fl_od0", 32'(out_data), 32'h0000);
        send_word(16'h0001);
        @(negedge clk);
        chk("fl_ov", 32'(out_valid), 32'd1);
        chk("fl_od", 32'(out_data), 32'h0001);
        in_valid = 1'b0;

        // reset in the middle of a word
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_bit = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("mr_fl9", 32'(fill_level), 32'd9);
        rst_n = 1'b0;
        #1 chk_reset_vals("mr_now");
        repeat (3) @(negedge clk);
        chk_reset_vals("mr_held");
        rst_n = 1'b1;
        send_word(16'h8001);
        @(negedge clk);
        chk("mr_ov", 32'(out_valid), 32'd1);
        chk("mr_od", 32'(out_data), 32'h8001);
        in_valid = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
